// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry in-order buffer feeding the register-file write port,
// with sticky overflow-trap capture and a saturating trap counter.
module alu_wb_stage #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_result,
  input  logic          in_overflow,
  input  logic [2:0]    in_opcode,
  input  logic [4:0]    in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [4:0]    out_rd,
  output logic          out_we,
  output logic          exc_flag,
  output logic [4:0]    exc_rd,
  input  logic          exc_clear,
  output logic [CW-1:0] ovf_count
);

  // state | meaning
  // EMPTY | no entries buffered
  // ONE   | slot 0 holds the head entry
  // TWO   | slots 0 and 1 both hold entries; input stalled
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          run;
  logic [DW-1:0] res0;
  logic [DW-1:0] res1;
  logic [4:0]    rd0;
  logic [4:0]    rd1;
  logic          we0;
  logic          we1;
  logic          in_acc;
  logic          out_acc;
  logic          trap;

  // run holds in_ready low until the first edge after reset release
  assign in_ready   = run & (state != TWO) & ~exc_flag;
  assign out_valid  = (state != EMPTY);
  assign out_result = res0;
  assign out_rd     = rd0;
  assign out_we     = out_valid & we0;

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;
  assign trap    = in_opcode[2] & in_overflow;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_acc) state_nxt = ONE;
      ONE: begin
        if (in_acc && !out_acc)      state_nxt = TWO;
        else if (out_acc && !in_acc) state_nxt = EMPTY;
      end
      TWO: if (out_acc) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      run   <= 1'b0;
      res0  <= '0;
      res1  <= '0;
      rd0   <= '0;
      rd1   <= '0;
      we0   <= 1'b0;
      we1   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      // slot 0 is always the head; a pop from TWO shifts slot 1 forward
      if (in_acc && (state == EMPTY || (state == ONE && out_acc))) begin
        res0 <= in_result;
        rd0  <= in_rd;
        we0  <= ~trap;
      end else if (in_acc) begin
        res1 <= in_result;
        rd1  <= in_rd;
        we1  <= ~trap;
      end else if (out_acc && state == TWO) begin
        res0 <= res1;
        rd0  <= rd1;
        we0  <= we1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_flag  <= 1'b0;
      exc_rd    <= '0;
      ovf_count <= '0;
    end else begin
      // in_acc already implies exc_flag == 0, so set and clear never collide
      if (in_acc && trap) begin
        exc_flag <= 1'b1;
        exc_rd   <= in_rd;
      end else if (exc_clear) begin
        exc_flag <= 1'b0;
      end
      if (in_acc && trap && (ovf_count != {CW{1'b1}}))
        ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Randomized and directed bench for alu_wb_stage against a queue-based reference model.
module tb_alu_wb_stage;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int OVF_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_result = '0;
  logic          in_overflow = 1'b0;
  logic [2:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_result;
  logic [4:0]    out_rd;
  logic          out_we;
  logic          exc_flag;
  logic [4:0]    exc_rd;
  logic          exc_clear = 1'b0;
  logic [CW-1:0] ovf_count;

  alu_wb_stage #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_overflow(in_overflow), .in_opcode(in_opcode), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_we(out_we),
    .exc_flag(exc_flag), .exc_rd(exc_rd), .exc_clear(exc_clear),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of entries plus exception state
  typedef struct packed {
    logic [DW-1:0] res;
    logic [4:0]    rd;
    logic          we;
  } ent_t;

  ent_t       q[$];
  bit         m_up = 0;
  bit         m_exc = 0;
  logic [4:0] m_exc_rd = '0;
  int         m_ovf = 0;

  function automatic bit m_in_ready();
    return m_up && (q.size() < 2) && !m_exc;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit acc_in, acc_out, is_trap;
    if (!rst_n) begin
      q.delete();
      m_up = 0;
      m_exc = 0;
      m_exc_rd = '0;
      m_ovf = 0;
    end else begin
      acc_in  = in_valid && m_in_ready();
      acc_out = out_ready && (q.size() > 0);
      is_trap = (in_opcode >= 3'd4) && in_overflow;
      if (acc_out) void'(q.pop_front());
      if (acc_in) q.push_back(ent_t'{in_result, in_rd, !is_trap});
      if (acc_in && is_trap) begin
        m_exc = 1;
        m_exc_rd = in_rd;
        if (m_ovf < OVF_MAX) m_ovf++;
      end else if (exc_clear) begin
        m_exc = 0;
      end
      m_up = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_we", out_we, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_exc_flag", exc_flag, 0);
      chk("rst_exc_rd", exc_rd, 0);
      chk("rst_ovf_count", ovf_count, 0);
    end else begin
      chk("in_ready", in_ready, m_in_ready());
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_result", out_result, q[0].res);
        chk("out_rd", out_rd, q[0].rd);
        chk("out_we", out_we, q[0].we);
      end else begin
        chk("out_we_idle", out_we, 0);
      end
      chk("exc_flag", exc_flag, m_exc);
      chk("exc_rd", exc_rd, m_exc_rd);
      chk("ovf_count", ovf_count, m_ovf);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Present an entry and hold it until accepted; returns 2 time units after the accepting edge
  task automatic push(input logic [2:0] op, input logic [DW-1:0] res, input logic ovf,
                      input logic [4:0] rd);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_opcode = op;
    in_result = res;
    in_overflow = ovf;
    in_rd = rd;
    for (int i = 0; i < 20 && !done; i++) begin
      done = in_ready;
      cyc();
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  logic [DW-1:0] got[$];

  initial begin
    bit c_go;
    // reset and release
    repeat (3) cyc();
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", in_ready, 0);
    cyc();
    chk("in_ready_after_edge", in_ready, 1);

    // simple non-trapping add
    out_ready = 1'b1;
    push(3'd5, 32'h7, 1'b0, 5'd3);
    chk("add_out_valid", out_valid, 1);
    chk("add_out_result", out_result, 32'h7);
    chk("add_out_rd", out_rd, 3);
    chk("add_out_we", out_we, 1);
    cyc();

    // overflow ignored for opcode 2
    push(3'd2, 32'hAB, 1'b1, 5'd4);
    chk("xor_out_we", out_we, 1);
    chk("xor_exc_flag", exc_flag, 0);
    chk("xor_ovf_count", ovf_count, 0);
    cyc();

    // trapping entry
    push(3'd5, 32'h55, 1'b1, 5'd9);
    chk("trap_out_we", out_we, 0);
    chk("trap_exc_flag", exc_flag, 1);
    chk("trap_exc_rd", exc_rd, 9);
    chk("trap_ovf_count", ovf_count, 1);
    chk("trap_in_ready", in_ready, 0);
    repeat (3) cyc();
    chk("trap_in_ready_held", in_ready, 0);
    exc_clear = 1'b1;
    cyc();
    exc_clear = 1'b0;
    chk("clear_exc_flag", exc_flag, 0);
    chk("clear_exc_rd", exc_rd, 9);
    chk("clear_in_ready", in_ready, 1);

    // back-pressure with A, B, C
    repeat (2) cyc();
    out_ready = 1'b0;
    push(3'd0, 32'hA, 1'b0, 5'd10);
    push(3'd1, 32'hB, 1'b0, 5'd11);
    in_valid = 1'b1;
    in_opcode = 3'd3;
    in_result = 32'hC;
    in_overflow = 1'b0;
    in_rd = 5'd12;
    chk("full_in_ready", in_ready, 0);
    repeat (3) cyc();
    chk("full_in_ready_held", in_ready, 0);
    chk("full_head_A", out_result, 32'hA);
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 12 && got.size() < 3; i++) begin
      if (out_valid) got.push_back(out_result);
      c_go = in_valid && in_ready;
      cyc();
      if (c_go) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("abc_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("abc_0", got[0], 32'hA);
      chk("abc_1", got[1], 32'hB);
      chk("abc_2", got[2], 32'hC);
    end

    // drive ovf_count to saturation, then one more trap
    for (int i = 0; i < OVF_MAX - 1; i++) begin
      push(3'd4, DW'(i), 1'b1, 5'(i));
      exc_clear = 1'b1;
      cyc();
      exc_clear = 1'b0;
    end
    chk("sat_reached", ovf_count, OVF_MAX);
    push(3'd7, 32'h1234, 1'b1, 5'd21);
    chk("sat_held", ovf_count, OVF_MAX);
    chk("sat_exc_rd", exc_rd, 21);
    exc_clear = 1'b1;
    cyc();
    exc_clear = 1'b0;

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_opcode   = 3'($urandom_range(0, 7));
      in_result   = $urandom;
      in_overflow = ($urandom_range(0, 3) == 0);
      in_rd       = 5'($urandom_range(0, 31));
      out_ready   = ($urandom_range(0, 2) != 0);
      exc_clear   = ($urandom_range(0, 3) == 0);
      cyc();
    end
    in_valid = 1'b0;
    exc_clear = 1'b1;
    out_ready = 1'b1;
    repeat (4) cyc();
    exc_clear = 1'b0;

    // reset with two entries buffered and an exception pending
    out_ready = 1'b0;
    push(3'd1, 32'h11, 1'b0, 5'd1);
    push(3'd6, 32'h22, 1'b1, 5'd2);
    chk("pre_rst_exc_flag", exc_flag, 1);
    chk("pre_rst_in_ready", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_result", out_result, 0);
    chk("mid_rst_out_rd", out_rd, 0);
    chk("mid_rst_out_we", out_we, 0);
    chk("mid_rst_exc_flag", exc_flag, 0);
    chk("mid_rst_exc_rd", exc_rd, 0);
    chk("mid_rst_ovf_count", ovf_count, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("post_rst_no_entries", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 Parameter DW, default 32, result data width.
REQ-002 Parameter CW, default 8, overflow-event counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream ALU result valid this cycle.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_result  input  DW  ALU output O.
REQ-008 in_overflow  input  1  ALU overflow flag.
REQ-009 in_opcode  input  3  ALU opcode that produced in_result.
REQ-010 in_rd  input  5  destination register index.
REQ-011 out_valid  output  1  head entry valid to register-file write port.
REQ-012 out_ready  input  1  downstream accepts head entry.
REQ-013 out_result  output  DW  head entry result.
REQ-014 out_rd  output  5  head entry destination.
REQ-015 out_we  output  1  head entry register write enable.
REQ-016 exc_flag  output  1  sticky overflow-exception flag.
REQ-017 exc_rd  output  5  destination of the first trapping entry.
REQ-018 exc_clear  input  1  one-cycle pulse clearing exc_flag.
REQ-019 ovf_count  output  CW  saturating count of trapping entries accepted.

Function
REQ-020 The stage SHALL hold a 2-entry in-order buffer with occupancy states EMPTY, ONE, TWO.
REQ-021 Input accept = in_valid & in_ready; output accept = out_valid & out_ready.
REQ-022 in_ready SHALL be 1 when occupancy < 2 and exc_flag = 0, else 0; it SHALL be registered/derived from current state only, never from in_valid.
REQ-023 out_valid SHALL equal (occupancy != EMPTY).
REQ-024 Transitions: EMPTY->ONE on input accept; ONE->TWO on input accept without output accept; ONE->EMPTY on output accept without input accept; ONE stays ONE on simultaneous accept; TWO->ONE on output accept.
REQ-025 An accepted entry SHALL appear on out_* the cycle after acceptance when the buffer was EMPTY (latency 1); order SHALL be strictly FIFO.
REQ-026 An entry is trapping iff in_opcode is 4..7 and in_overflow = 1; in_overflow SHALL be ignored for opcodes 0..3.
REQ-027 Each entry SHALL store we = ~trapping; out_we SHALL equal the head entry's stored we, and 0 when out_valid = 0.
REQ-028 On accepting a trapping entry with exc_flag = 0: exc_flag SHALL set and exc_rd SHALL capture in_rd on that edge.
REQ-029 While exc_flag = 1, in_ready = 0; buffered entries SHALL still drain downstream.
REQ-030 exc_clear = 1 SHALL clear exc_flag on the next edge; exc_rd SHALL retain its value; exc_clear with exc_flag = 0 SHALL have no effect.
REQ-031 Trapping and clear cannot coincide: accept is blocked while exc_flag = 1, so set has priority only when exc_flag = 0.
REQ-032 ovf_count SHALL increment by 1 per accepted trapping entry and saturate at 2^CW-1.
REQ-033 out_result and out_rd SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-034 Non-head buffer contents SHALL not be observable on outputs.

Reset
REQ-035 While rst_n = 0, occupancy = EMPTY, out_valid = 0, out_we = 0, out_result = 0, out_rd = 0, exc_flag = 0, exc_rd = 0, ovf_count = 0, asynchronously.
REQ-036 in_ready SHALL be 0 while rst_n = 0 and 1 from the first edge after release.
REQ-037 Reset mid-operation SHALL discard buffered entries; none SHALL emerge after release.

Verification
REQ-038 Add opcode 5, result 0x00000007, rd 3, no overflow, out_ready = 1 -> next cycle out_valid = 1, out_result = 0x00000007, out_rd = 3, out_we = 1.
REQ-039 Opcode 5, in_overflow = 1, rd 9 -> out_we = 0 for that entry, exc_flag = 1, exc_rd = 9, ovf_count = 1, in_ready = 0 until exc_clear pulse, then in_ready = 1 next cycle.
REQ-040 Opcode 2 (XOR) with in_overflow = 1 -> out_we = 1, exc_flag stays 0, ovf_count unchanged.
REQ-041 out_ready = 0, three back-to-back valid entries A,B,C -> A,B accepted, in_ready = 0 while C held; release out_ready -> outputs A,B,C in order, no loss or duplication.
REQ-042 Force ovf_count to 2^CW-1 via repeated trap/clear cycles, one more trap -> ovf_count stays 2^CW-1.
REQ-043 Assert rst_n = 0 with occupancy TWO and exc_flag = 1 -> all outputs zero immediately, no entries after release.
